// File: rtl/banco_registradores_sb.sv
// Two-read/two-write register file with a destination-register scoreboard for hazard stalls.
// Latency: reads and busy flags are combinational (with write bypass); writes, reservations and pend_count settle at the next edge.
// Backpressure: none; every asserted write or reserve is accepted, and the decode stage stalls on rs_busy/rt_busy.
module banco_registradores_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [ADDR_W:0]   pend_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pend_nxt;

    logic wr0;
    logic wr1;
    logic rsv_set;
    logic cnt_inc;
    logic cnt_dec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Bypass priority mirrors write priority: port 0 beats port 1 on the same address.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic              w0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              w1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1,
        input logic [DATA_W-1:0] stored
    );
        if (is_zero(a))
            return '0;
        else if (w0 && (a0 == a))
            return d0;
        else if (w1 && (a1 == a))
            return d1;
        else
            return stored;
    endfunction

    assign wr0     = we0 && !is_zero(waddr0);
    assign wr1     = we1 && !is_zero(waddr1);
    assign rsv_set = rsv_en && !is_zero(rsv_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr0 && (waddr0 == ADDR_W'(i)))
                    regs[i] <= wdata0;
                else if (wr1 && (waddr1 == ADDR_W'(i)))
                    regs[i] <= wdata1;
            end
        end
    end

    // A reservation issued in the same cycle as the writeback it overtakes must survive.
    always_comb begin
        pend_nxt = pending;
        if (wr1)
            pend_nxt[waddr1] = 1'b0;
        if (rsv_set)
            pend_nxt[rsv_addr] = 1'b1;
    end

    assign cnt_inc = rsv_set && !pending[rsv_addr];
    assign cnt_dec = wr1 && pending[waddr1] && !(rsv_set && (rsv_addr == waddr1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending <= pend_nxt;
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_count <= pend_count + (ADDR_W+1)'(1);
                2'b01:   pend_count <= pend_count - (ADDR_W+1)'(1);
                default: pend_count <= pend_count;
            endcase
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        if (!reset) begin
            rs_data = read_port(rs, we0, waddr0, wdata0, we1, waddr1, wdata1, regs[rs]);
            rt_data = read_port(rt, we0, waddr0, wdata0, we1, waddr1, wdata1, regs[rt]);
            rs_busy = pending[rs] && !(we1 && (waddr1 == rs));
            rt_busy = pending[rt] && !(we1 && (waddr1 == rt));
        end
    end

endmodule

// File: tb/tb_banco_registradores_sb.sv
// Directed bench for banco_registradores_sb; expected values are queued as stimulus is driven and popped at each check.
module tb_banco_registradores_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic [ADDR_W:0]   pend_count;

    logic [31:0] exp_q [$];
    int n_cmp;
    int n_err;

    banco_registradores_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .ZERO_REG(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .we0(we0),
        .waddr0(waddr0),
        .wdata0(wdata0),
        .we1(we1),
        .waddr1(waddr1),
        .wdata1(wdata1),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .rs(rs),
        .rt(rt),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .rs_busy(rs_busy),
        .rt_busy(rt_busy),
        .pend_count(pend_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, want);
            end
        end
    endtask

    // Drive new inputs just after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; rsv_addr = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        rs = 5'd5;
        rt = 5'd5;
        // Bypass must be suppressed while reset is high.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678;
        #2;
        expect_v(32'h0); check("reset_rs_data", rs_data);
        expect_v(32'h0); check("reset_rt_data", rt_data);
        expect_v(32'h0); check("reset_pend_count", 32'(pend_count));
        expect_v(32'h0); check("reset_rs_busy", 32'(rs_busy));
        @(posedge clock);
        #7;
        reset = 1'b0;
        idle();
        #1;
        expect_v(32'h0); check("write_during_reset_dropped", rs_data);

        // Port 0 write with same-cycle bypass, then from storage.
        tick();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; rs = 5'd5;
        expect_v(32'hDEAD_BEEF);
        #1; check("bypass_we0", rs_data);
        tick();
        idle();
        expect_v(32'hDEAD_BEEF);
        #1; check("stored_we0", rs_data);

        // Collision: port 0 data wins in bypass and in storage.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        rt = 5'd7;
        expect_v(32'h11);
        #1; check("collision_bypass", rt_data);
        tick();
        idle();
        expect_v(32'h11);
        #1; check("collision_stored", rt_data);

        // Register 0 ignores writes and reservations.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; rs = 5'd0;
        expect_v(32'h0);
        #1; check("r0_bypass", rs_data);
        tick();
        idle();
        expect_v(32'h0); expect_v(32'h0); expect_v(32'h0);
        #1;
        check("r0_stored", rs_data);
        check("r0_busy", 32'(rs_busy));
        check("r0_pend_count", 32'(pend_count));

        // Scoreboard: reserve r3, then release via port 1.
        rsv_en = 1'b1; rsv_addr = 5'd3; rs = 5'd3;
        expect_v(32'h0);
        #1; check("rsv_no_comb_path", 32'(rs_busy));
        tick();
        idle();
        expect_v(32'h1); expect_v(32'h1);
        #1;
        check("r3_busy", 32'(rs_busy));
        check("r3_pend_count", 32'(pend_count));
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hABCD;
        expect_v(32'h0); expect_v(32'hABCD); expect_v(32'h1);
        #1;
        check("r3_release_busy", 32'(rs_busy));
        check("r3_release_data", rs_data);
        check("r3_release_count_before_edge", 32'(pend_count));
        tick();
        idle();
        expect_v(32'h0); expect_v(32'hABCD);
        #1;
        check("r3_released_count", 32'(pend_count));
        check("r3_stored", rs_data);

        // Set and clear of r9 in one cycle: the new reservation wins.
        rsv_en = 1'b1; rsv_addr = 5'd9; rt = 5'd9;
        tick();
        idle();
        expect_v(32'h1);
        #1; check("r9_pend_count", 32'(pend_count));
        rsv_en = 1'b1; rsv_addr = 5'd9;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
        expect_v(32'h0);
        #1; check("r9_setclr_busy_same_cycle", 32'(rt_busy));
        tick();
        idle();
        expect_v(32'h1); expect_v(32'h1); expect_v(32'h99);
        #1;
        check("r9_setclr_count", 32'(pend_count));
        check("r9_still_busy", 32'(rt_busy));
        check("r9_data", rt_data);

        // Fill r1, r2, r4, then reset between edges.
        rsv_en = 1'b1; rsv_addr = 5'd1;
        tick();
        rsv_addr = 5'd2;
        tick();
        rsv_addr = 5'd4;
        tick();
        idle();
        rs = 5'd1; rt = 5'd9;
        expect_v(32'h4); expect_v(32'h1); expect_v(32'h1);
        #1;
        check("fill_pend_count", 32'(pend_count));
        check("fill_rs_busy", 32'(rs_busy));
        check("fill_rt_busy", 32'(rt_busy));
        #1;
        reset = 1'b1;
        #1;
        expect_v(32'h0); expect_v(32'h0); expect_v(32'h0);
        check("async_reset_count", 32'(pend_count));
        check("async_reset_rs_busy", 32'(rs_busy));
        check("async_reset_rt_busy", 32'(rt_busy));
        rs = 5'd5; rt = 5'd3;
        #1;
        expect_v(32'h0); expect_v(32'h0);
        check("async_reset_rs_data", rs_data);
        check("async_reset_rt_data", rt_data);
        tick();
        reset = 1'b0;
        tick();
        expect_v(32'h0); expect_v(32'h0);
        #1;
        check("post_reset_r5", rs_data);
        check("post_reset_count", 32'(pend_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/banco_registradores_sb.md
# banco_registradores_sb

Parametrised two-read / two-write general-purpose register file with an integrated scoreboard, the next-generation register bank for the SICA 32-bit core. Write port 0 serves single-cycle ALU writeback. Write port 1 serves long-latency writeback (load/multiply). Reads are combinational, with same-cycle write bypass. The scoreboard tracks destination registers reserved by in-flight long-latency instructions so the decode stage can stall on hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes, and cannot be reserved

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and scoreboard
- we0  in  1  write enable, port 0 (ALU)
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (long-latency); also releases the scoreboard entry
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- rsv_en  in  1  reserve destination register in scoreboard
- rsv_addr  in  ADDR_W  register to reserve
- rs  in  ADDR_W  read address A
- rt  in  ADDR_W  read address B
- rs_data  out  DATA_W  read data A (bypassed)
- rt_data  out  DATA_W  read data B (bypassed)
- rs_busy  out  1  register rs is pending and not released this cycle
- rt_busy  out  1  register rt is pending and not released this cycle
- pend_count  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: NREGS x DATA_W registers plus an NREGS-bit pending vector.
- Write: on the rising edge, regs[waddrN] <= wdataN for each asserted weN.
- Same-address collision (we0 & we1 & waddr0==waddr1): port 0 data is stored.
- The pending bit is still cleared by port 1 in a collision.
- ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0 regardless of bypass.
- Read bypass: rs_data returns wdata0 if we0 & waddr0==rs.
  - Otherwise it returns wdata1 if we1 & waddr1==rs.
  - Otherwise it returns regs[rs].
  - rt_data follows the same rule. Bypass priority matches write priority.
- Scoreboard set: rsv_en sets pending[rsv_addr] at the edge. Reserving an already-pending register leaves it 1; this is not an error.
- Scoreboard clear: we1 clears pending[waddr1] at the edge. we0 never touches pending.
- Set and clear of the same address in one cycle: the set wins and pending stays 1 (new reservation overtakes old writeback).
- Set and clear of different addresses in one cycle: both apply.
- ZERO_REG=1: reservation of address 0 is ignored, so pending[0] is always 0.
- Busy: rs_busy = pending[rs] & ~(we1 & waddr1==rs), which is combinational and reflects the bypass release. rt_busy follows the same rule.
- pend_count: a registered population count of pending, updated at each edge. The net change per cycle is -1, 0 or +1, and no wrap is possible since the maximum is NREGS.

## Timing
- Reset asserted:
  - All registers and pending bits are cleared immediately (asynchronously), and pend_count = 0.
  - Write and reserve inputs are ignored while reset is high.
  - Bypass is disabled, so rs_data = rt_data = 0 and rs_busy = rt_busy = 0.
- Reset deasserted: the first active edge is the first edge after deassertion.
- Reset mid-operation: all pending reservations are lost. The pipeline is flushed by the same reset, so no recovery behaviour is needed.
- Read latency: 0 cycles (combinational from rs/rt and the write ports).
- Write-to-storage latency: 1 edge. A value written at edge k is read from storage from edge k onward, and is visible via bypass during the cycle before edge k.
- Reserve-to-busy latency: 1 edge. rsv_en in cycle k gives busy from cycle k+1.
- No combinational path from rsv_en/rsv_addr to any output.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port 0 and read rs=5 in the same cycle -> rs_data=0xDEADBEEF via bypass. After the edge, with we0=0, rs_data stays 0xDEADBEEF.
- Set we0=1, waddr0=7, wdata0=0x11, and in the same cycle set we1=1, waddr1=7, wdata1=0x22 -> rt_data(rt=7)=0x11 in that cycle and after the edge.
- With ZERO_REG=1, write 0xFFFFFFFF to r0 on both ports and set rsv_en to address 0 -> rs_data(rs=0)=0, rs_busy=0, pend_count=0.
- Scoreboard cycle:
  - Reserve r3 -> next cycle rs_busy=1, pend_count=1.
  - Then we1 to r3 with 0xABCD -> same cycle rs_busy=0 and rs_data=0xABCD.
  - Next cycle pend_count=0.
- Reserve r9 and write r9 via we1 in the same cycle, where r9 was pending -> pending[r9] stays 1 and pend_count is unchanged.
- Reserve r1, r2, r4 in successive cycles and assert reset asynchronously between edges -> pend_count=0, all busy=0, all reads 0 immediately, without waiting for an edge.
